wts_timer_multi: RTL and testbench
==================================

Name: wts_timer_multi

Overview:
Parametrised N-channel programmable interval timer. It is the successor to the fixed two-flag timer interrupt block in the wave table sound core.
- Each channel has a down-counter with a reload value, periodic or one-shot mode, a sticky interrupt flag and an overrun flag.
- All channels count a shared prescaled timebase derived from an external tick strobe.
- The block drives a masked, active-low combined interrupt to the host bus.

Parameters:
CHANNELS, 2, number of timer channels (1..8)
COUNT_WIDTH, 16, width of each channel counter and reload value
PRESCALE_WIDTH, 8, width of shared prescaler counter and divider value

Ports:
nreset  in  1  asynchronous active-low reset
clk  in  1  system clock, all state on rising edge
tick  in  1  one-clk timebase strobe (e.g. sample-rate pulse)
reg_prescale  in  PRESCALE_WIDTH  divider value P; timebase = tick/(P+1)
reg_reload  in  COUNT_WIDTH  shared reload data bus
reg_load  in  CHANNELS  per-channel strobe: latch reg_reload into reload register and counter
reg_enable  in  CHANNELS  per-channel run enable (level)
reg_oneshot  in  CHANNELS  per-channel mode: 0 periodic, 1 one-shot
reg_clear  in  CHANNELS  per-channel strobe: clear interrupt and overrun flags
reg_mask  in  CHANNELS  per-channel interrupt enable onto nint
interrupt  out  CHANNELS  sticky expiry flags (unmasked)
overrun  out  CHANNELS  sticky flag: expiry while interrupt already set
running  out  CHANNELS  channel armed and counting
nint  out  1  ~|(interrupt & reg_mask), active low

Behaviour:
- Reset: prescaler=0, all counters=0, reload registers=0, interrupt=0, overrun=0, running=0, nint=1.
- Prescaler:
  - On tick: if prescaler==reg_prescale, emit internal strobe ts (1 clk) and wrap to 0; else increment.
  - Without tick, prescaler holds.
  - P=0 gives ts on every tick.
  - A change of reg_prescale below the current count makes the prescaler count up to all-ones and wrap before matching.
- Channel arming:
  - reg_load[i] loads counter and reload register from reg_reload.
  - reg_load[i] sets running[i] if reg_enable[i]=1.
  - A rising edge of reg_enable[i] sets running[i] and reloads the counter from the reload register.
  - reg_enable[i]=0 clears running[i] the next clk; the counter holds.
- Counting:
  - On ts with running[i]=1: if counter!=0, decrement; if counter==0, expire.
  - The period is therefore reload+1 timebase strobes; reload=0 expires on every ts.
- Expiry:
  - Set interrupt[i].
  - If interrupt[i] was already 1 (and not cleared this clk), set overrun[i].
  - Periodic: counter reloads from the reload register in the same clk.
  - One-shot: running[i] clears and the counter stays 0.
- Flag visibility: flags are registered. interrupt rises one clk after the ts cycle; nint falls combinationally from the registered flags.
- Simultaneous events, same clk:
  - clear+expiry: flags end with interrupt=1, overrun=0, so no event is lost.
  - load+ts: load wins, no decrement.
  - load+enable rising: single load from reg_reload.
- Channels are fully independent; vector bits map 1:1 to channel index.
- Reset mid-count aborts everything immediately, with no pending expiry.

Test Plan:
1. P=0, ch0 reload=3 periodic, enable, tick every clk -> interrupt[0] rises one clk after every 4th tick; running[0]=1 throughout; nint=0 with mask=1.
2. P=2, ch1 reload=1 one-shot, tick every clk -> single expiry on the 6th tick, running[1]=0 afterwards, no further flags after clear.
3. ch0 periodic reload=0, never cleared -> interrupt[0] on 1st ts, overrun[0] on 2nd ts; reg_clear[0] -> both 0, nint=1.
4. Assert reg_clear[0] in the exact expiry cycle -> interrupt[0]=1, overrun[0]=0 afterwards.
5. Two channels expiring together, mask=2'b01 -> interrupt=2'b11; nint=0 while ch0 set; clear ch0 -> nint=1 with interrupt=2'b10.
6. Assert nreset mid-count with flags set -> all outputs at reset values immediately; after release, ch0 needs reg_load or an enable edge to run.

Source files
------------

// File: rtl/wts_timer_multi.sv
// wts_timer_multi: N-channel programmable interval timer on a shared prescaled
// timebase, with sticky per-channel expiry/overrun flags and a masked
// active-low combined interrupt.
module wts_timer_multi #(
  parameter int unsigned CHANNELS       = 2,
  parameter int unsigned COUNT_WIDTH    = 16,
  parameter int unsigned PRESCALE_WIDTH = 8
) (
  input  logic                      nreset,
  input  logic                      clk,
  input  logic                      tick,
  input  logic [PRESCALE_WIDTH-1:0] reg_prescale,
  input  logic [COUNT_WIDTH-1:0]    reg_reload,
  input  logic [CHANNELS-1:0]       reg_load,
  input  logic [CHANNELS-1:0]       reg_enable,
  input  logic [CHANNELS-1:0]       reg_oneshot,
  input  logic [CHANNELS-1:0]       reg_clear,
  input  logic [CHANNELS-1:0]       reg_mask,
  output logic [CHANNELS-1:0]       interrupt,
  output logic [CHANNELS-1:0]       overrun,
  output logic [CHANNELS-1:0]       running,
  output logic                      nint
);

  logic [PRESCALE_WIDTH-1:0] presc_q;
  logic                      ts_c;

  // Timebase strobe: the tick that lands on the divider match.
  assign ts_c = tick && (presc_q == reg_prescale);

  // Shared prescaler; an exact-match compare means a divider lowered below the
  // current count runs through the all-ones wrap before matching again.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= ts_c ? '0 : presc_q + PRESCALE_WIDTH'(1);
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [COUNT_WIDTH-1:0] reload_q, reload_d;
    logic                   run_q, run_d;
    logic                   en_q;
    logic                   int_q, int_d;
    logic                   ovr_q, ovr_d;
    logic                   expire_c;

    // Next-state for one channel: load beats enable edge beats disable beats counting.
    always_comb begin
      count_d  = count_q;
      reload_d = reload_q;
      run_d    = run_q;
      expire_c = 1'b0;
      if (reg_load[g]) begin
        reload_d = reg_reload;
        count_d  = reg_reload;
        run_d    = reg_enable[g];
      end else if (reg_enable[g] && !en_q) begin
        count_d = reload_q;
        run_d   = 1'b1;
      end else if (!reg_enable[g]) begin
        run_d = 1'b0;
      end else if (ts_c && run_q) begin
        if (count_q != '0) begin
          count_d = count_q - COUNT_WIDTH'(1);
        end else begin
          expire_c = 1'b1;
          if (reg_oneshot[g]) begin
            run_d = 1'b0;
          end else begin
            count_d = reload_q;
          end
        end
      end
      // A clear in the expiry cycle still leaves the new expiry visible.
      int_d = (int_q & ~reg_clear[g]) | expire_c;
      ovr_d = (ovr_q & ~reg_clear[g]) | (expire_c & int_q & ~reg_clear[g]);
    end

    // Channel state; the enable history resets high so an enable held through
    // reset does not count as an arming edge.
    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
        count_q  <= '0;
        reload_q <= '0;
        run_q    <= 1'b0;
        en_q     <= 1'b1;
        int_q    <= 1'b0;
        ovr_q    <= 1'b0;
      end else begin
        count_q  <= count_d;
        reload_q <= reload_d;
        run_q    <= run_d;
        en_q     <= reg_enable[g];
        int_q    <= int_d;
        ovr_q    <= ovr_d;
      end
    end

    assign interrupt[g] = int_q;
    assign overrun[g]   = ovr_q;
    assign running[g]   = run_q;
  end

  // Combined host interrupt straight from the registered flags.
  assign nint = ~|(interrupt & reg_mask);

endmodule

// File: tb/tb_wts_timer_multi.sv
// Directed and randomized bench for wts_timer_multi against a behavioural model.
module tb_wts_timer_multi;
  localparam int CH = 2;
  localparam int CW = 16;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          nreset;
  logic          tick;
  logic [PW-1:0] reg_prescale;
  logic [CW-1:0] reg_reload;
  logic [CH-1:0] reg_load, reg_enable, reg_oneshot, reg_clear, reg_mask;
  logic [CH-1:0] interrupt, overrun, running;
  logic          nint;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: ticks seen since last timebase, strobes left before expiry.
  int m_pre;
  int m_left [CH];
  int m_rel  [CH];
  bit m_run  [CH];
  bit m_int  [CH];
  bit m_ovr  [CH];
  bit m_en_prev [CH];

  wts_timer_multi #(.CHANNELS(CH), .COUNT_WIDTH(CW), .PRESCALE_WIDTH(PW)) dut (
    .nreset(nreset), .clk(clk), .tick(tick), .reg_prescale(reg_prescale),
    .reg_reload(reg_reload), .reg_load(reg_load), .reg_enable(reg_enable),
    .reg_oneshot(reg_oneshot), .reg_clear(reg_clear), .reg_mask(reg_mask),
    .interrupt(interrupt), .overrun(overrun), .running(running), .nint(nint)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_pre = 0;
    for (int c = 0; c < CH; c++) begin
      m_left[c] = 1; m_rel[c] = 0; m_run[c] = 0;
      m_int[c] = 0; m_ovr[c] = 0; m_en_prev[c] = 1;
    end
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  function automatic void model_step();
    bit ts;
    bit expire;
    if (!nreset) begin
      model_reset();
      return;
    end
    ts = tick && (m_pre == int'(reg_prescale));
    if (tick) m_pre = ts ? 0 : (m_pre + 1) % (1 << PW);
    for (int c = 0; c < CH; c++) begin
      expire = 0;
      if (reg_load[c]) begin
        m_rel[c]  = int'(reg_reload);
        m_left[c] = m_rel[c] + 1;
        m_run[c]  = reg_enable[c];
      end else if (reg_enable[c] && !m_en_prev[c]) begin
        m_left[c] = m_rel[c] + 1;
        m_run[c]  = 1;
      end else if (!reg_enable[c]) begin
        m_run[c] = 0;
      end else if (ts && m_run[c]) begin
        m_left[c] = m_left[c] - 1;
        if (m_left[c] == 0) begin
          expire = 1;
          if (reg_oneshot[c]) begin
            m_run[c]  = 0;
            m_left[c] = 1;
          end else begin
            m_left[c] = m_rel[c] + 1;
          end
        end
      end
      m_en_prev[c] = reg_enable[c];
      if (reg_clear[c]) begin
        m_ovr[c] = 0;
        m_int[c] = expire;
      end else begin
        if (expire && m_int[c]) m_ovr[c] = 1;
        if (expire) m_int[c] = 1;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [CH-1:0] ei, eo, er;
    for (int c = 0; c < CH; c++) begin
      ei[c] = m_int[c]; eo[c] = m_ovr[c]; er[c] = m_run[c];
    end
    check("m_interrupt", 32'(interrupt), 32'(ei));
    check("m_overrun",   32'(overrun),   32'(eo));
    check("m_running",   32'(running),   32'(er));
    check("m_nint",      32'(nint),      32'(~|(ei & reg_mask)));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    nreset = 1'b0; tick = 1'b0; reg_load = '0; reg_clear = '0; reg_enable = '0;
    reg_oneshot = '0; reg_mask = '0; reg_prescale = '0; reg_reload = '0;
    cycle();
    check("rst_int",  32'(interrupt), 0);
    check("rst_ovr",  32'(overrun), 0);
    check("rst_run",  32'(running), 0);
    check("rst_nint", 32'(nint), 1);
    nreset = 1'b1;
  endtask

  initial begin
    model_reset();
    nreset = 1'b0; tick = 1'b0; reg_prescale = '0; reg_reload = '0;
    reg_load = '0; reg_enable = '0; reg_oneshot = '0; reg_clear = '0; reg_mask = '0;

    // 1: periodic reload=3, P=0, tick every clk
    do_reset();
    reg_mask = 2'b01; reg_reload = 16'd3; reg_enable = 2'b01; reg_load = 2'b01;
    cycle();
    reg_load = '0;
    check("t1_run", 32'(running[0]), 1);
    tick = 1'b1;
    repeat (3) cycle();
    check("t1_int_early", 32'(interrupt[0]), 0);
    cycle();
    check("t1_int", 32'(interrupt[0]), 1);
    check("t1_nint", 32'(nint), 0);
    reg_clear = 2'b01;
    cycle();
    reg_clear = '0;
    check("t1_cleared", 32'(interrupt[0]), 0);
    repeat (2) cycle();
    check("t1_int2_early", 32'(interrupt[0]), 0);
    cycle();
    check("t1_int2", 32'(interrupt[0]), 1);
    check("t1_run2", 32'(running[0]), 1);

    // 2: one-shot reload=1, P=2 -> expiry on 6th tick
    do_reset();
    reg_prescale = 8'd2; reg_reload = 16'd1; reg_oneshot = 2'b10;
    reg_enable = 2'b10; reg_mask = 2'b10; reg_load = 2'b10;
    cycle();
    reg_load = '0; tick = 1'b1;
    repeat (5) cycle();
    check("t2_int_early", 32'(interrupt[1]), 0);
    check("t2_run_early", 32'(running[1]), 1);
    cycle();
    check("t2_int", 32'(interrupt[1]), 1);
    check("t2_run_done", 32'(running[1]), 0);
    check("t2_nint", 32'(nint), 0);
    reg_clear = 2'b10;
    cycle();
    reg_clear = '0;
    repeat (12) cycle();
    check("t2_quiet", 32'(interrupt[1]), 0);
    check("t2_still_stopped", 32'(running[1]), 0);

    // 3: reload=0 periodic, overrun on second ts, then clear
    do_reset();
    reg_reload = '0; reg_enable = 2'b01; reg_mask = 2'b01; reg_load = 2'b01;
    cycle();
    reg_load = '0; tick = 1'b1;
    cycle();
    check("t3_int", 32'(interrupt[0]), 1);
    check("t3_ovr0", 32'(overrun[0]), 0);
    cycle();
    check("t3_ovr", 32'(overrun[0]), 1);
    tick = 1'b0; reg_clear = 2'b01;
    cycle();
    reg_clear = '0;
    check("t3_clr_int", 32'(interrupt[0]), 0);
    check("t3_clr_ovr", 32'(overrun[0]), 0);
    check("t3_nint", 32'(nint), 1);

    // 4: clear in the exact expiry cycle
    tick = 1'b1;
    cycle();
    check("t4_pre", 32'(interrupt[0]), 1);
    reg_clear = 2'b01;
    cycle();
    reg_clear = '0; tick = 1'b0;
    check("t4_int", 32'(interrupt[0]), 1);
    check("t4_ovr", 32'(overrun[0]), 0);

    // 5: two channels expire together, only ch0 unmasked
    do_reset();
    reg_reload = 16'd2; reg_enable = 2'b11; reg_mask = 2'b01; reg_load = 2'b11;
    cycle();
    reg_load = '0; tick = 1'b1;
    repeat (3) cycle();
    check("t5_int", 32'(interrupt), 32'h3);
    check("t5_nint", 32'(nint), 0);
    tick = 1'b0; reg_clear = 2'b01;
    cycle();
    reg_clear = '0;
    check("t5_int_after", 32'(interrupt), 32'h2);
    check("t5_nint_after", 32'(nint), 1);

    // 6: asynchronous reset mid-count with flags set
    tick = 1'b1;
    cycle();
    #2;
    nreset = 1'b0;
    model_reset();
    #1;
    check("t6_int", 32'(interrupt), 0);
    check("t6_ovr", 32'(overrun), 0);
    check("t6_run", 32'(running), 0);
    check("t6_nint", 32'(nint), 1);
    repeat (2) cycle();
    nreset = 1'b1;
    repeat (5) cycle();
    check("t6_no_rearm", 32'(running), 0);
    check("t6_no_int", 32'(interrupt), 0);
    reg_enable = 2'b00;
    cycle();
    reg_enable = 2'b01;
    cycle();
    check("t6_edge_arm", 32'(running[0]), 1);
    cycle();
    check("t6_edge_expire", 32'(interrupt[0]), 1);

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      nreset = ($urandom_range(0, 249) != 0);
      tick = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 59) == 0) reg_prescale = PW'($urandom_range(0, 3));
      reg_reload = CW'($urandom_range(0, 5));
      for (int c = 0; c < CH; c++) begin
        reg_load[c]  = ($urandom_range(0, 15) == 0);
        reg_clear[c] = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 19) == 0) reg_enable[c] = ~reg_enable[c];
        if ($urandom_range(0, 29) == 0) reg_oneshot[c] = ~reg_oneshot[c];
        if ($urandom_range(0, 9) == 0) reg_mask[c] = ~reg_mask[c];
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
